// File: rtl/cnn_pkg.sv
// Shared CNN back-end definitions: score geometry and the argmax scan state encoding.
package cnn_pkg;

    localparam int SCORE_W   = 13;
    localparam int N_CLASSES = 5;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/score_argmax_if.sv
// Score/result bundle between the conv layer, the argmax block and the readout logic.
interface score_argmax_if #(
    parameter int N_CLASSES = cnn_pkg::N_CLASSES,
    parameter int SCORE_W   = cnn_pkg::SCORE_W,
    parameter int IDX_W     = cnn_pkg::IDX_W
) ();

    logic                           start;
    logic [N_CLASSES*SCORE_W-1:0]   scores;
    logic [IDX_W-1:0]               class_idx;
    logic signed [SCORE_W-1:0]      max_score;
    logic [SCORE_W-1:0]             margin;
    logic                           valid;
    logic                           done;
    logic                           dropped;

    modport master (
        output start, scores,
        input  class_idx, max_score, margin, valid, done, dropped
    );

    modport slave (
        input  start, scores,
        output class_idx, max_score, margin, valid, done, dropped
    );

endinterface

// File: rtl/score_argmax.sv
// Captures N signed class scores on a rising start edge and scans them serially,
// reporting the winning index, winning score and margin to the runner-up.
module score_argmax
    import cnn_pkg::*;
#(
    parameter int N_CLASSES = cnn_pkg::N_CLASSES,
    parameter int SCORE_W   = cnn_pkg::SCORE_W,
    parameter int IDX_W     = cnn_pkg::IDX_W
) (
    input  logic           clk,
    input  logic           rst,
    score_argmax_if.slave  bus
);

    state_t                    state, state_n;
    logic                      start_q;
    logic                      rise;
    logic signed [SCORE_W-1:0] sc_r [N_CLASSES];
    logic signed [SCORE_W-1:0] best, second;
    logic [IDX_W-1:0]          idx, i_r;
    logic                      last;

    logic signed [SCORE_W-1:0] s, best_n, second_n;
    logic [IDX_W-1:0]          idx_n;
    logic signed [SCORE_W:0]   diff;
    logic                      capture, step, finish;

    logic [IDX_W-1:0]          cls_r;
    logic signed [SCORE_W-1:0] max_r;
    logic [SCORE_W-1:0]        mar_r;
    logic                      valid_r, done_r, drop_r;

    assign rise = bus.start & ~start_q;
    assign last = (i_r == IDX_W'(N_CLASSES - 1));

    always_comb begin
        state_n = state;
        capture = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    capture = 1'b1;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                step = 1'b1;
                if (last) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strictly-greater replacement keeps the lowest index on ties; an equal value
    // still lands in the runner-up slot so the margin reports 0.
    always_comb begin
        s        = sc_r[i_r];
        best_n   = best;
        second_n = second;
        idx_n    = idx;
        if (s > best) begin
            second_n = best;
            best_n   = s;
            idx_n    = i_r;
        end else if (s > second) begin
            second_n = s;
        end
        diff = (SCORE_W+1)'(best_n) - (SCORE_W+1)'(second_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
            for (int unsigned k = 0; k < N_CLASSES; k++) sc_r[k] <= '0;
            best    <= '0;
            second  <= '0;
            idx     <= '0;
            i_r     <= '0;
            cls_r   <= '0;
            max_r   <= '0;
            mar_r   <= '0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            drop_r  <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= bus.start;
            done_r  <= finish;
            drop_r  <= rise && (state != IDLE);
            if (capture) begin
                for (int unsigned k = 0; k < N_CLASSES; k++)
                    sc_r[k] <= bus.scores[k*SCORE_W +: SCORE_W];
                best    <= bus.scores[SCORE_W-1:0];
                second  <= {1'b1, {(SCORE_W-1){1'b0}}};
                idx     <= '0;
                i_r     <= IDX_W'(1);
                valid_r <= 1'b0;
            end
            if (step) begin
                best   <= best_n;
                second <= second_n;
                idx    <= idx_n;
                i_r    <= i_r + IDX_W'(1);
            end
            if (finish) begin
                cls_r   <= idx_n;
                max_r   <= best_n;
                mar_r   <= diff[SCORE_W-1:0];
                valid_r <= 1'b1;
            end
        end
    end

    assign bus.class_idx = cls_r;
    assign bus.max_score = max_r;
    assign bus.margin    = mar_r;
    assign bus.valid     = valid_r;
    assign bus.done      = done_r;
    assign bus.dropped   = drop_r;

endmodule
